// File: rtl/eight_bit_sequential_divider.sv
// rtl/eight_bit_sequential_divider.sv - multi-cycle signed restoring divider, one quotient bit per clock
//
// Purpose:
//   Signed two's-complement division (truncating toward zero, remainder takes
//   the dividend's sign) using a restoring shift/subtract loop. A start/busy/done
//   handshake issues one division at a time.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset; clears all state and outputs
//   start        request, sampled only while idle
//   dividend     signed dividend, sampled with start
//   divisor      signed divisor, sampled with start
//   busy         high from the accepting edge until the edge that raises done
//   done         one-cycle pulse; results valid from this cycle onward
//   quotient     signed quotient (registered)
//   remainder    signed remainder (registered)
//   overflow     set for most-negative / -1
//   div_by_zero  set when divisor was zero
module eight_bit_sequential_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             overflow,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FIXUP  = 2'd2
  } state_t;

  localparam logic [3:0]       COUNT_INIT = 4'(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state, state_next;

  logic [3:0]       count;
  // Holds the dividend magnitude at start; dividend bits shift out of the top
  // while quotient bits shift in at the bottom, so it ends as the quotient.
  logic [WIDTH-1:0] quo_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] part_rem;
  logic             sign_dvd;
  logic             sign_dvs;
  logic             zero_div;
  logic             ovf_case;

  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             trial_ok;

  // Magnitude of the most negative value wraps back to itself, which reads
  // correctly as an unsigned 2^(WIDTH-1).
  assign dvd_abs = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvs_abs = divisor[WIDTH-1]  ? -divisor  : divisor;

  // part_rem < divisor magnitude always, so the shifted value fits WIDTH+1
  // bits and the sign bit of the difference is the restore decision.
  assign shifted  = {part_rem, quo_mag[WIDTH-1]};
  assign diff     = shifted - {1'b0, dvs_mag};
  assign trial_ok = ~diff[WIDTH];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) state_next = (divisor == '0) ? FIXUP : DIVIDE;
      end
      DIVIDE: begin
        if (count == 4'd1) state_next = FIXUP;
      end
      FIXUP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      count       <= '0;
      quo_mag     <= '0;
      dvs_mag     <= '0;
      part_rem    <= '0;
      sign_dvd    <= 1'b0;
      sign_dvs    <= 1'b0;
      zero_div    <= 1'b0;
      ovf_case    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sign_dvd    <= dividend[WIDTH-1];
            sign_dvs    <= divisor[WIDTH-1];
            quo_mag     <= dvd_abs;
            dvs_mag     <= dvs_abs;
            part_rem    <= '0;
            count       <= COUNT_INIT;
            zero_div    <= (divisor == '0);
            ovf_case    <= (dividend == MOST_NEG) && (divisor == '1);
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
          end
        end
        DIVIDE: begin
          part_rem <= trial_ok ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
          quo_mag  <= {quo_mag[WIDTH-2:0], trial_ok};
          count    <= count - 4'd1;
        end
        FIXUP: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (zero_div) begin
            // quo_mag was never shifted, so it still carries |dividend|.
            quotient    <= '0;
            remainder   <= sign_dvd ? -quo_mag : quo_mag;
            div_by_zero <= 1'b1;
          end else begin
            quotient  <= (sign_dvd ^ sign_dvs) ? -quo_mag : quo_mag;
            remainder <= sign_dvd ? -part_rem : part_rem;
            overflow  <= ovf_case;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
